// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : pll_seq_pkg
// Sequencer state encoding, default parameters and counter sizing helper.
// Rev     : 1.0
// ============================================================================
package pll_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int C_SYNC_STAGES   = 2;
    localparam int C_STABLE_CYCLES = 1024;
    localparam int C_STAGE_GAP     = 16;
    localparam int C_NUM_STAGES    = 3;
    localparam int C_CNT_W         = 8;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lock_sync.sv
`default_nettype none
// ============================================================================
// Module : lock_sync
// Single-bit SYNC_STAGES-flop synchroniser, synchronous reset to 0.
// Rev    : 1.0
// ============================================================================
module lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_rst_seq.sv
`default_nettype none
// ============================================================================
// Module : pll_lock_rst_seq
// Lock-qualified staggered reset release; loss counter under PLL_LOCK_LOSS_CNT_EN.
// Rev    : 1.0
// ============================================================================
module pll_lock_rst_seq
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES   = C_SYNC_STAGES,
    parameter int STABLE_CYCLES = C_STABLE_CYCLES,
    parameter int STAGE_GAP     = C_STAGE_GAP,
    parameter int NUM_STAGES    = C_NUM_STAGES,
    parameter int CNT_W         = C_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lock_in,
    input  logic                  clr_sticky,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [CNT_W-1:0]      loss_cnt
);

    localparam int c_stab_w = cnt_width(STABLE_CYCLES);
    localparam int c_gap_w  = cnt_width(STAGE_GAP);
    localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(STABLE_CYCLES - 1);
    localparam logic [c_gap_w-1:0]  c_gap_last  = c_gap_w'(STAGE_GAP - 1);

    logic                  w_lock_s;
    seq_state_t            r_state;
    logic [c_stab_w-1:0]   r_stab_cnt;
    logic [c_gap_w-1:0]    r_gap_cnt;
    logic [NUM_STAGES-1:0] r_rst_out;
    logic                  r_ready;
    logic                  r_lock_lost;

    lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (lock_in),
        .sync_out (w_lock_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= WAIT_LOCK;
            r_stab_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_rst_out   <= '1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            // A loss on the same edge overrides the clear below.
            if (clr_sticky) begin
                r_lock_lost <= 1'b0;
            end
            case (r_state)
                WAIT_LOCK: begin
                    r_stab_cnt <= '0;
                    r_rst_out  <= '1;
                    r_ready    <= 1'b0;
                    if (w_lock_s) begin
                        r_state <= STABLE;
                    end
                end
                STABLE: begin
                    if (!w_lock_s) begin
                        r_state    <= WAIT_LOCK;
                        r_stab_cnt <= '0;
                    end else if (r_stab_cnt == c_stab_last) begin
                        r_state    <= RELEASE;
                        r_stab_cnt <= '0;
                        r_gap_cnt  <= '0;
                        r_rst_out  <= r_rst_out << 1;
                    end else begin
                        r_stab_cnt <= r_stab_cnt + 1'b1;
                    end
                end
                RELEASE, RUN: begin
                    if (!w_lock_s) begin
                        r_state     <= WAIT_LOCK;
                        r_rst_out   <= '1;
                        r_ready     <= 1'b0;
                        r_lock_lost <= 1'b1;
                    end else if (r_state == RELEASE) begin
                        // Zero-filling shift releases bit 0 first, then each higher domain.
                        if (r_gap_cnt == c_gap_last) begin
                            r_gap_cnt <= '0;
                            if (r_rst_out == '0) begin
                                r_state <= RUN;
                                r_ready <= 1'b1;
                            end else begin
                                r_rst_out <= r_rst_out << 1;
                            end
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= WAIT_LOCK;
            endcase
        end
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic             w_loss;
    logic [CNT_W-1:0] r_loss_cnt;

    assign w_loss = ((r_state == RELEASE) || (r_state == RUN)) && !w_lock_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_loss_cnt <= '0;
        end else if (w_loss) begin
            if (clr_sticky) begin
                r_loss_cnt <= CNT_W'(1);
            end else if (r_loss_cnt != '1) begin
                r_loss_cnt <= r_loss_cnt + 1'b1;
            end
        end else if (clr_sticky) begin
            r_loss_cnt <= '0;
        end
    end

    assign loss_cnt = r_loss_cnt;
`else
    assign loss_cnt = '0;
`endif

    assign rst_out   = r_rst_out;
    assign ready     = r_ready;
    assign lock_lost = r_lock_lost;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_rst_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_pll_lock_rst_seq
// Scoreboard bench: expected outputs queued by edge number, compared at negedge.
// Rev    : 1.0
// ============================================================================
module tb_pll_lock_rst_seq;

    localparam int NS = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lock_in = 1'b0;
    logic          clr_sticky = 1'b0;
    logic [NS-1:0] rst_out;
    logic          ready;
    logic          lock_lost;
    logic [CW-1:0] loss_cnt;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int    at;
        int    sel;
        int    exp;
        string tag;
    } exp_t;

    exp_t sb[$];

    pll_lock_rst_seq #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (16),
        .STAGE_GAP     (4),
        .NUM_STAGES    (NS),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lock_in    (lock_in),
        .clr_sticky (clr_sticky),
        .rst_out    (rst_out),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .loss_cnt   (loss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lc(input int v);
`ifdef PLL_LOCK_LOSS_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // sel: 0 rst_out, 1 ready, 2 lock_lost, 3 loss_cnt
    function automatic void sb_push(input int at, input int sel, input int exp, input string tag);
        exp_t e;
        int   i;
        e.at = at; e.sel = sel; e.exp = exp; e.tag = tag;
        i = 0;
        while (i < sb.size() && sb[i].at <= at) i++;
        sb.insert(i, e);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sb_compare();
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            case (e.sel)
                0:       got = 32'(rst_out);
                1:       got = 32'(ready);
                2:       got = 32'(lock_lost);
                default: got = 32'(loss_cnt);
            endcase
            check(e.tag, got, 32'(e.exp));
        end
    endtask

    // Lock raised after edge e0: full staggered release schedule.
    task automatic push_release(input int e0);
        sb_push(e0 + 18, 0, 7, "rst_hold");
        sb_push(e0 + 19, 0, 6, "rst0_rel");
        sb_push(e0 + 22, 0, 6, "rst1_hold");
        sb_push(e0 + 23, 0, 4, "rst1_rel");
        sb_push(e0 + 26, 0, 4, "rst2_hold");
        sb_push(e0 + 27, 0, 0, "rst2_rel");
        sb_push(e0 + 30, 1, 0, "ready_early");
        sb_push(e0 + 31, 1, 1, "ready_rise");
    endtask

    // Relock, enter RELEASE, then drop lock while rst_out==110.
    task automatic relock_and_drop(input int exp_cnt, input bit clr_same);
        int e0;
        e0 = cyc;
        lock_in = 1'b1;
        sb_push(e0 + 19, 0, 6, "rel_entry");
        tick(19);
        lock_in = 1'b0;
        sb_push(e0 + 21, 0, 6, "rel_pre_loss");
        sb_push(e0 + 22, 0, 7, "rel_loss_rst");
        sb_push(e0 + 22, 2, 1, "rel_loss_lost");
        sb_push(e0 + 22, 3, lc(exp_cnt), "rel_loss_cnt");
        if (clr_same) begin
            tick(2);
            clr_sticky = 1'b1;
            tick(1);
            clr_sticky = 1'b0;
            tick(1);
        end else begin
            tick(4);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        fork
            forever begin
                @(negedge clk);
                sb_compare();
            end
        join_none

        // Reset values
        sb_push(2, 0, 7, "rst_rst_out");
        sb_push(2, 1, 0, "rst_ready");
        sb_push(2, 2, 0, "rst_lost");
        sb_push(2, 3, 0, "rst_cnt");
        tick(3);
        rst = 1'b0;

        // Clean bring-up
        e0 = cyc;
        lock_in = 1'b1;
        push_release(e0);
        sb_push(e0 + 31, 2, 0, "bringup_lost");
        tick(32);

        // Loss in RUN
        e0 = cyc;
        lock_in = 1'b0;
        sb_push(e0 + 2, 0, 0, "run_pre_rst");
        sb_push(e0 + 2, 1, 1, "run_pre_ready");
        sb_push(e0 + 3, 0, 7, "run_loss_rst");
        sb_push(e0 + 3, 1, 0, "run_loss_ready");
        sb_push(e0 + 3, 2, 1, "run_loss_lost");
        sb_push(e0 + 3, 3, lc(1), "run_loss_cnt");
        tick(5);

        // Glitch during qualification, then loss in RELEASE
        e0 = cyc;
        lock_in = 1'b1;
        sb_push(e0 + 28, 0, 7, "glitch_hold");
        sb_push(e0 + 29, 0, 6, "glitch_rel");
        sb_push(e0 + 29, 3, lc(1), "glitch_cnt");
        tick(9);
        lock_in = 1'b0;
        tick(1);
        lock_in = 1'b1;
        tick(19);
        e0 = cyc;
        lock_in = 1'b0;
        sb_push(e0 + 2, 0, 6, "rel2_pre");
        sb_push(e0 + 3, 0, 7, "rel2_loss_rst");
        sb_push(e0 + 3, 3, lc(2), "rel2_loss_cnt");
        tick(4);

        // Saturation
        relock_and_drop(3, 1'b0);
        relock_and_drop(3, 1'b0);

        // Clear sticky state
        e0 = cyc;
        clr_sticky = 1'b1;
        sb_push(e0, 2, 1, "clr_pre_lost");
        sb_push(e0 + 1, 2, 0, "clr_lost");
        sb_push(e0 + 1, 3, 0, "clr_cnt");
        tick(1);
        clr_sticky = 1'b0;
        tick(1);

        // Clear coincident with a loss
        relock_and_drop(1, 1'b1);

        // Synchronous reset mid-RELEASE
        e0 = cyc;
        lock_in = 1'b1;
        tick(24);
        sb_push(e0 + 24, 0, 4, "mrst_pre_rst");
        sb_push(e0 + 24, 2, 1, "mrst_pre_lost");
        sb_push(e0 + 25, 0, 7, "mrst_rst_out");
        sb_push(e0 + 25, 1, 0, "mrst_ready");
        sb_push(e0 + 25, 2, 0, "mrst_lost");
        sb_push(e0 + 25, 3, 0, "mrst_cnt");
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        lock_in = 1'b0;
        tick(4);

        while (sb.size() > 0) begin
            check({"expired_", sb[0].tag}, 32'(cyc), 32'(sb[0].at));
            void'(sb.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
